// File: rtl/hc194_seq_ctrl.sv
// Sequencer for a 4-bit HC194 universal shift register: loads a seed, then
// alternates STEPS right-shifts and STEPS left-shifts, one step every DIV cycles.
module hc194_seq_ctrl #(
    parameter int DIV   = 4,
    parameter int STEPS = 3,
    parameter int CNT_W = 8
) (
    input  logic       Clk,
    input  logic       MR,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Pause,
    input  logic       Ring,
    input  logic       Fill,
    input  logic [3:0] Seed,
    input  logic [3:0] Q_fb,
    output logic [1:0] S,
    output logic [3:0] D,
    output logic       DSR,
    output logic       DSL,
    output logic       Dir,
    output logic       Busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SHR, SHL} state_t;

    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHR  = 2'b01;
    localparam logic [1:0] S_SHL  = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
    localparam logic [3:0]       STEPS_LAST = 4'(STEPS - 1);

    state_t           state;
    logic [CNT_W-1:0] div_cnt;
    logic [3:0]       step_cnt;

    logic step_now;
    logic last_step;
    logic dir_next;
    logic wrap;

    assign DSR = Ring ? Q_fb[3] : Fill;
    assign DSL = Ring ? Q_fb[0] : Fill;

    // The registered S tells us whether the cycle now ending was a step cycle.
    assign step_now  = (S == S_SHR) || (S == S_SHL);
    assign last_step = step_now && (step_cnt == STEPS_LAST);
    assign dir_next  = Dir ^ last_step;
    assign wrap      = !Pause && (div_cnt == DIV_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            state    <= IDLE;
            S        <= S_HOLD;
            D        <= 4'b0000;
            Dir      <= 1'b0;
            Busy     <= 1'b0;
            div_cnt  <= '0;
            step_cnt <= '0;
        end else if (Stop) begin
            state    <= IDLE;
            S        <= S_HOLD;
            Dir      <= 1'b0;
            Busy     <= 1'b0;
            div_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    S <= S_HOLD;
                    if (Start) begin
                        state    <= LOAD;
                        S        <= S_LOAD;
                        D        <= Seed;
                        Dir      <= 1'b0;
                        Busy     <= 1'b1;
                        div_cnt  <= '0;
                        step_cnt <= '0;
                    end
                end
                default: begin
                    // The LOAD cycle counts as the first divider cycle, so the
                    // first step lands DIV cycles after it.
                    if (step_now) step_cnt <= last_step ? 4'd0 : step_cnt + 4'd1;
                    if (!Pause)   div_cnt  <= wrap ? '0 : div_cnt + CNT_W'(1);
                    Dir   <= dir_next;
                    state <= dir_next ? SHL : SHR;
                    S     <= wrap ? (dir_next ? S_SHL : S_SHR) : S_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hc194_seq_ctrl.sv
// Bench for hc194_seq_ctrl: a behavioural HC194 closes the loop, a queue
// scoreboard holds expected Q after every step, plus direct S/Busy/Dir checks.
module tb_hc194_seq_ctrl;

    logic       clk = 1'b0;
    logic       mr;
    logic       start, stop, pause, ring, fill;
    logic [3:0] seed;
    logic [3:0] q_a;
    logic [1:0] s_a;
    logic [3:0] d_a;
    logic       dsr_a, dsl_a, dir_a, busy_a;

    logic       start_b;
    logic [1:0] s_b;
    logic [3:0] d_b;
    logic       dsr_b, dsl_b, dir_b, busy_b;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [3:0] exp_q[$];
    logic [1:0] s_seen = 2'b00;
    logic       mon_en = 1'b0;
    int         n_load;

    always #5 clk = ~clk;

    hc194_seq_ctrl #(.DIV(2), .STEPS(3), .CNT_W(8)) u_dut (
        .Clk(clk), .MR(mr), .Start(start), .Stop(stop), .Pause(pause),
        .Ring(ring), .Fill(fill), .Seed(seed), .Q_fb(q_a),
        .S(s_a), .D(d_a), .DSR(dsr_a), .DSL(dsl_a), .Dir(dir_a), .Busy(busy_a)
    );

    hc194_seq_ctrl #(.DIV(1), .STEPS(1), .CNT_W(4)) u_dut_b (
        .Clk(clk), .MR(mr), .Start(start_b), .Stop(1'b0), .Pause(1'b0),
        .Ring(1'b0), .Fill(1'b0), .Seed(4'b0101), .Q_fb(4'b0000),
        .S(s_b), .D(d_b), .DSR(dsr_b), .DSL(dsl_b), .Dir(dir_b), .Busy(busy_b)
    );

    // Behavioural HC194 sharing clock and MR with the sequencer.
    always @(posedge clk or negedge mr) begin
        if (!mr) q_a <= 4'b0000;
        else begin
            case (s_a)
                2'b01:   q_a <= {q_a[2:0], dsr_a};
                2'b10:   q_a <= {dsl_a, q_a[3:1]};
                2'b11:   q_a <= d_a;
                default: q_a <= q_a;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every step cycle must move Q to the next queued value.
    always @(negedge clk) s_seen <= s_a;

    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && (s_seen == 2'b01 || s_seen == 2'b10)) begin
                if (exp_q.size() == 0) check("sb_underflow", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("q_step", q_a, e);
                end
            end
        end
    end

    initial begin
        logic [1:0] s_exp;
        int         j;
        mr = 1'b0; start = 0; stop = 0; pause = 0; ring = 0; fill = 0;
        seed = 4'b0000; start_b = 0;
        repeat (2) tick();

        // Reset state
        check("rst_s", s_a, 2'b00);
        check("rst_d", d_a, 4'b0000);
        check("rst_busy", busy_a, 0);
        check("rst_dir", dir_a, 0);
        check("rst_q", q_a, 4'b0000);
        mr = 1'b1;
        tick();

        // Ping-pong, Ring=0, Fill=0, Seed=0001
        seed = 4'b0001;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100); exp_q.push_back(4'b0010); exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
        mon_en = 1'b1;
        start  = 1'b1;
        tick();
        check("load_s", s_a, 2'b11);
        check("load_busy", busy_a, 1);
        check("load_d", d_a, 4'b0001);
        start = 1'b0;
        tick();
        check("load_q", q_a, 4'b0001);
        check("post_load_s", s_a, 2'b00);
        for (int k = 1; k <= 16; k++) begin
            tick();
            j = (k + 1) / 2;
            if (k % 2 == 1) s_exp = (((j - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
            else            s_exp = 2'b00;
            check("pp_s", s_a, s_exp);
            check("pp_dir", dir_a, (k >= 6 && k <= 11) ? 1 : 0);
        end
        check("pp_sb_empty", exp_q.size(), 0);

        // Pause for 5 cycles with one step pending
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("pause_s", s_a, 2'b00);
            check("pause_q", q_a, 4'b0100);
        end
        pause = 1'b0;
        exp_q.push_back(4'b1000);
        tick();
        check("resume_s", s_a, 2'b01);
        tick();
        check("resume_gap_s", s_a, 2'b00);
        exp_q.push_back(4'b0100);
        tick();
        check("turn_s", s_a, 2'b10);
        check("turn_dir", dir_a, 1);
        tick();

        // Stop mid-SHL
        stop = 1'b1;
        tick();
        check("stop_s", s_a, 2'b00);
        check("stop_busy", busy_a, 0);
        stop = 1'b0;
        tick();
        check("stop_hold_q", q_a, 4'b0100);
        tick();
        check("stop_hold_q2", q_a, 4'b0100);
        check("stop_sb_empty", exp_q.size(), 0);

        // Serial input mux
        fill = 1'b1; ring = 1'b0;
        #1;
        check("dsr_fill", dsr_a, 1);
        check("dsl_fill", dsl_a, 1);
        ring = 1'b1;
        #1;
        check("dsr_ring", dsr_a, q_a[3]);
        check("dsl_ring", dsl_a, q_a[0]);
        fill = 1'b0;

        // Start together with Stop in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        check("startstop_busy", busy_a, 0);
        check("startstop_s", s_a, 2'b00);
        start = 1'b0; stop = 1'b0;
        tick();

        // Ring mode, Seed=1001, Start held high while busy
        seed = 4'b1001; ring = 1'b1;
        exp_q.push_back(4'b0011); exp_q.push_back(4'b0110); exp_q.push_back(4'b1100);
        exp_q.push_back(4'b0110); exp_q.push_back(4'b0011);
        start  = 1'b1;
        n_load = 0;
        tick();
        if (s_a == 2'b11) n_load++;
        tick();
        check("ring_load_q", q_a, 4'b1001);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (s_a == 2'b11) n_load++;
        end
        check("ring_single_load", n_load, 1);
        check("ring_sb_empty", exp_q.size(), 0);
        check("ring_dir", dir_a, 1);
        start  = 1'b0;
        mon_en = 1'b0;

        // Asynchronous reset mid-run
        #2;
        mr = 1'b0;
        #1;
        check("arst_s", s_a, 2'b00);
        check("arst_d", d_a, 4'b0000);
        check("arst_busy", busy_a, 0);
        check("arst_dir", dir_a, 0);
        check("arst_q", q_a, 4'b0000);
        tick();
        mr = 1'b1;
        tick();

        // DIV=1, STEPS=1 instance: 11, 01, 10, 01, 10 ...
        start_b = 1'b1;
        tick();
        check("b_load_s", s_b, 2'b11);
        check("b_load_d", d_b, 4'b0101);
        start_b = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("b_s", s_b, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("b_dir", dir_b, (k % 2 == 0) ? 0 : 1);
            check("b_busy", busy_b, 1);
        end
        check("b_dsr", dsr_b, 0);
        check("b_dsl", dsl_b, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
